// File: rtl/uram_rmw.sv
// uram_rmw: simple-dual-port URAM with hardware init sweep and forwarded read-modify-write engine
module uram_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              cmd_en,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_ADD = 2'b10;
  typedef enum logic {INIT, IDLE} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_cnt;
  logic r_s1_v;
  logic [1:0] r_s1_op;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic [DATA_W-1:0] r_ram_q;
  logic r_fwd_v;
  logic [ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_clr, w_acc, w_we, w_rsp;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_old, w_new, w_wdata;
  assign busy = r_state == INIT;
  always_comb begin
    w_clr = r_state == IDLE && clr;
    w_acc = r_state == IDLE && cmd_en && !clr;
    w_state_nx = (r_state == INIT && &r_cnt) ? IDLE : w_clr ? INIT : r_state;
    w_old = (r_fwd_v && r_fwd_addr == r_s1_addr) ? r_fwd_data : r_ram_q;
    w_new = r_s1_op == OP_WR ? r_s1_data :
            r_s1_op == OP_ADD ? w_old + r_s1_data :
            (w_old < r_s1_data) ? w_old : r_s1_data;
    w_rsp = r_s1_v && r_s1_op != OP_WR;
    w_we = !rst && (r_state == INIT || (r_s1_v && r_s1_op != OP_RD));
    w_waddr = r_state == INIT ? r_cnt : r_s1_addr;
    w_wdata = r_state == INIT ? INIT_VAL : w_new;
  end
  always_ff @(posedge clk)
    r_state <= rst ? INIT : w_state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_s1_v <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      r_fwd_v <= 1'b0;
    end else begin
      r_cnt <= r_state == INIT ? r_cnt + ADDR_W'(1) : '0;
      r_s1_v <= w_acc;
      rsp_valid <= w_rsp;
      rsp_data <= w_rsp ? w_old : rsp_data;
      r_fwd_v <= w_we && !w_clr;
    end
  end
  always_ff @(posedge clk) begin
    r_s1_op <= cmd_op;
    r_s1_addr <= cmd_addr;
    r_s1_data <= cmd_data;
    r_fwd_addr <= w_waddr;
    r_fwd_data <= w_wdata;
    r_ram_q <= r_mem[cmd_addr];
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
endmodule
